// File: rtl/execute.sv
// EX stage of the 16-bit pipelined CPU: ALU, shift, compare, address and branch-target compute.
// Latency 1 clk: every output is the EX/MEM register loaded on the rising edge of clk.
// No backpressure: the stage accepts one instruction per cycle unconditionally.
module execute #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        control_in,
    input  logic [4:0]        dest_index_in,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    input  logic [DATA_W-1:0] npc,
    input  logic [IMM_W-1:0]  immediate,
    output logic [4:0]        dest_index_out,
    output logic [4:0]        control_out,
    output logic [DATA_W-1:0] output_reg,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] target,
    output logic              DEST_REG_WRITE_EN,
    output logic              ZF,
    output logic              GF,
    output logic              LF
);

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_SUB    = 4'h1,
        OP_ADD    = 4'h2,
        OP_ADDI   = 4'h3,
        OP_SHLLI  = 4'h4,
        OP_SHRLI  = 4'h5,
        OP_JUMP   = 4'h6,
        OP_JUMPL  = 4'h7,
        OP_JUMPG  = 4'h8,
        OP_JUMPE  = 4'h9,
        OP_JUMPNE = 4'hA,
        OP_CMP    = 4'hB,
        OP_LOAD   = 4'hC,
        OP_LOADI  = 4'hD,
        OP_STORE  = 4'hE,
        OP_MOV    = 4'hF
    } op_t;

    op_t               op;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;
    logic [3:0]        shamt;
    logic [DATA_W-1:0] result_d;
    logic              we_d;
    logic              taken;
    logic [DATA_W-1:0] target_d;

    assign op    = op_t'(control_in[3:0]);
    assign simm  = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
    assign zimm  = {{(DATA_W-IMM_W){1'b0}}, immediate};
    assign shamt = immediate[3:0];

    // Opcode decode: result, write enable and branch decision (jumps use the already-registered flags).
    always_comb begin
        result_d = '0;
        we_d     = 1'b0;
        taken    = 1'b0;
        case (op)
            OP_SUB:    begin result_d = reg1_data - reg2_data; we_d = 1'b1; end
            OP_ADD:    begin result_d = reg1_data + reg2_data; we_d = 1'b1; end
            OP_ADDI:   begin result_d = reg1_data + simm;      we_d = 1'b1; end
            OP_SHLLI:  begin result_d = reg1_data << shamt;    we_d = 1'b1; end
            OP_SHRLI:  begin result_d = reg1_data >> shamt;    we_d = 1'b1; end
            OP_JUMP:   taken = 1'b1;
            OP_JUMPL:  taken = LF;
            OP_JUMPG:  taken = GF;
            OP_JUMPE:  taken = ZF;
            OP_JUMPNE: taken = ~ZF;
            OP_LOAD:   begin result_d = reg1_data + simm;      we_d = 1'b1; end
            OP_LOADI:  begin result_d = zimm;                  we_d = 1'b1; end
            OP_STORE:  result_d = reg1_data + simm;
            OP_MOV:    begin result_d = reg1_data;             we_d = 1'b1; end
            default:   ;
        endcase
        target_d = taken ? (npc + simm) : npc;
    end

    // EX/MEM pipeline register; flags change only on CMP so later jumps can test them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_index_out    <= '0;
            control_out       <= '0;
            output_reg        <= '0;
            result_out        <= '0;
            target            <= '0;
            DEST_REG_WRITE_EN <= 1'b0;
            ZF                <= 1'b0;
            GF                <= 1'b0;
            LF                <= 1'b0;
        end else begin
            dest_index_out    <= dest_index_in;
            control_out       <= control_in;
            output_reg        <= reg2_data;
            result_out        <= result_d;
            target            <= target_d;
            DEST_REG_WRITE_EN <= we_d;
            if (op == OP_CMP) begin
                ZF <= (reg1_data == reg2_data);
                GF <= (reg1_data >  reg2_data);
                LF <= (reg1_data <  reg2_data);
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage with hand-computed expected values.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Single checking task counts every comparison and reports mismatches.
module tb_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  control_in;
    logic [4:0]  dest_index_in;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [15:0] npc;
    logic [6:0]  immediate;
    logic [4:0]  dest_index_out;
    logic [4:0]  control_out;
    logic [15:0] output_reg;
    logic [15:0] result_out;
    logic [15:0] target;
    logic        DEST_REG_WRITE_EN;
    logic        ZF, GF, LF;

    int n_checks = 0;
    int n_fail   = 0;

    execute dut (
        .clk               (clk),
        .reset             (reset),
        .control_in        (control_in),
        .dest_index_in     (dest_index_in),
        .reg1_data         (reg1_data),
        .reg2_data         (reg2_data),
        .npc               (npc),
        .immediate         (immediate),
        .dest_index_out    (dest_index_out),
        .control_out       (control_out),
        .output_reg        (output_reg),
        .result_out        (result_out),
        .target            (target),
        .DEST_REG_WRITE_EN (DEST_REG_WRITE_EN),
        .ZF                (ZF),
        .GF                (GF),
        .LF                (LF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one instruction at the falling edge, then advance past the next rising edge.
    task automatic issue(input logic [4:0] ctl, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] pc1, input logic [6:0] imm, input logic [4:0] dst);
        @(negedge clk);
        control_in    = ctl;
        reg1_data     = r1;
        reg2_data     = r2;
        npc           = pc1;
        immediate     = imm;
        dest_index_in = dst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic g, input logic l);
        check({tag, ".flags"}, {13'd0, ZF, GF, LF}, {13'd0, z, g, l});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dest"},   {11'd0, dest_index_out}, 16'h0);
        check({tag, ".ctl"},    {11'd0, control_out},    16'h0);
        check({tag, ".oreg"},   output_reg,              16'h0);
        check({tag, ".res"},    result_out,              16'h0);
        check({tag, ".tgt"},    target,                  16'h0);
        check({tag, ".we"},     {15'd0, DEST_REG_WRITE_EN}, 16'h0);
        check_flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        control_in    = '0;
        dest_index_in = '0;
        reg1_data     = '0;
        reg2_data     = '0;
        npc           = '0;
        immediate     = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // SUB 10-3, dest 2
        issue(5'h01, 16'd10, 16'd3, 16'd1, 7'd0, 5'd2);
        check("sub.res",  result_out, 16'd7);
        check("sub.we",   {15'd0, DEST_REG_WRITE_EN}, 16'd1);
        check("sub.dest", {11'd0, dest_index_out}, 16'd2);
        check("sub.tgt",  target, 16'd1);

        issue(5'h02, 16'd10, 16'd5, 16'd2, 7'd0, 5'd3);
        check("add.res", result_out, 16'd15);
        issue(5'h03, 16'd10, 16'd0, 16'd3, 7'd7, 5'd3);
        check("addi.pos", result_out, 16'd17);
        issue(5'h03, 16'd10, 16'd0, 16'd4, 7'h7F, 5'd3);
        check("addi.neg", result_out, 16'd9);
        issue(5'h01, 16'd3, 16'd10, 16'd5, 7'd0, 5'd4);
        check("sub.wrap", result_out, 16'hFFF9);
        issue(5'h04, 16'h8001, 16'd0, 16'd6, 7'd1, 5'd5);
        check("shlli", result_out, 16'h0002);
        issue(5'h05, 16'h8001, 16'd0, 16'd7, 7'd1, 5'd5);
        check("shrli", result_out, 16'h4000);
        // shift amount uses only immediate[3:0]: 7'h13 -> 3
        issue(5'h04, 16'h0001, 16'd0, 16'd8, 7'h13, 5'd5);
        check("shlli.amt", result_out, 16'h0008);
        issue(5'h0D, 16'h1234, 16'd0, 16'd9, 7'h7F, 5'd6);
        check("loadi.zext", result_out, 16'h007F);
        // MOV with control bit 4 set: passes through untouched
        issue(5'h1F, 16'hA5A5, 16'h1111, 16'd10, 7'd0, 5'd7);
        check("mov.res", result_out, 16'hA5A5);
        check("mov.ctl", {11'd0, control_out}, 16'h001F);
        check("mov.oreg", output_reg, 16'h1111);
        issue(5'h0C, 16'd100, 16'd0, 16'd11, 7'h7E, 5'd8);
        check("load.addr", result_out, 16'd98);
        check("load.we", {15'd0, DEST_REG_WRITE_EN}, 16'd1);

        // CMP equal, then jumps
        issue(5'h0B, 16'd5, 16'd5, 16'd12, 7'd0, 5'd0);
        check_flags("cmp.eq", 1'b1, 1'b0, 1'b0);
        check("cmp.res", result_out, 16'h0);
        check("cmp.we", {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        issue(5'h09, 16'd0, 16'd0, 16'd20, 7'h7C, 5'd0);
        check("jumpe.tgt", target, 16'd16);
        check("jumpe.we", {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        issue(5'h0A, 16'd0, 16'd0, 16'd20, 7'h7C, 5'd0);
        check("jumpne.tgt", target, 16'd20);
        issue(5'h08, 16'd0, 16'd0, 16'd30, 7'd5, 5'd0);
        check("jumpg.nt", target, 16'd30);
        issue(5'h06, 16'd0, 16'd0, 16'd30, 7'd5, 5'd0);
        check("jump.tgt", target, 16'd35);

        // CMP less, flags persist across ADD
        issue(5'h0B, 16'd2, 16'd9, 16'd1, 7'd0, 5'd0);
        check_flags("cmp.lt", 1'b0, 1'b0, 1'b1);
        issue(5'h02, 16'd1, 16'd1, 16'd2, 7'd0, 5'd1);
        check_flags("add.keep", 1'b0, 1'b0, 1'b1);
        issue(5'h07, 16'd0, 16'd0, 16'd4, 7'd3, 5'd0);
        check("jumpl.tgt", target, 16'd7);
        issue(5'h0E, 16'd100, 16'hBEEF, 16'd5, 7'd2, 5'd9);
        check("store.oreg", output_reg, 16'hBEEF);
        check("store.addr", result_out, 16'd102);
        check("store.we", {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        check("store.tgt", target, 16'd5);

        // CMP greater; JUMPG taken, JUMPE not
        issue(5'h0B, 16'hFFFF, 16'd1, 16'd50, 7'd0, 5'd0);
        check_flags("cmp.gt", 1'b0, 1'b1, 1'b0);
        issue(5'h08, 16'd0, 16'd0, 16'd50, 7'h70, 5'd0);
        check("jumpg.tgt", target, 16'd34);
        issue(5'h09, 16'd0, 16'd0, 16'd50, 7'h70, 5'd0);
        check("jumpe.nt", target, 16'd50);

        // NOP passes dest/ctl/store data, clears result and WE
        issue(5'h10, 16'd7, 16'h5A5A, 16'd60, 7'd1, 5'd17);
        check("nop.res", result_out, 16'h0);
        check("nop.we", {15'd0, DEST_REG_WRITE_EN}, 16'd0);
        check("nop.oreg", output_reg, 16'h5A5A);
        check("nop.dest", {11'd0, dest_index_out}, 16'd17);
        check("nop.ctl", {11'd0, control_out}, 16'h0010);

        // Async reset mid-cycle
        issue(5'h02, 16'd40, 16'd2, 16'd61, 7'd0, 5'd12);
        check("pre_rst.res", result_out, 16'd42);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        issue(5'h01, 16'd100, 16'd1, 16'd70, 7'd0, 5'd13);
        check("post_rst.res", result_out, 16'd99);
        check("post_rst.we", {15'd0, DEST_REG_WRITE_EN}, 16'd1);
        check_flags("post_rst", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
